// File: rtl/core_seq_ctrl.sv
// Instruction sequencer for the 2D accelerator core: turns one start command into
// the per-cycle weight-load, activation-stream and PSUM-drain instruction stream.
module core_seq_ctrl #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int addr_bw = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic [addr_bw-1:0] w_base,
  input  logic [addr_bw-1:0] x_base,
  input  logic [addr_bw-1:0] p_base,
  input  logic [addr_bw-1:0] num_x,
  input  logic               ofifo_valid,
  output logic [34:0]        inst,
  output logic               busy,
  output logic               done
);

  localparam int CW = addr_bw + 1;
  localparam logic [34:0] IdleWord = 35'h1800C0000;
  localparam logic [CW-1:0] LastWload = CW'(row);
  localparam logic [CW-1:0] LastWexec = CW'(row + col - 1);

  typedef enum logic [2:0] {
    IDLE, WLOAD, WEXEC, XSTREAM, DRAIN, DONE
  } stateT;

  stateT state, stateNext;
  logic [CW-1:0] cnt, cntNext;
  logic [addr_bw-1:0] wcnt, wcntNext;
  logic modeQ;
  logic [addr_bw-1:0] wBase, xBase, pBase, numX;
  logic [34:0] instNext;

  logic modeBit, pCen, pWen, xCen, xWen, ofRd, l0Wr, exec, load, drainWr;
  logic [addr_bw-1:0] pAddr, xAddr;

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    wcntNext  = wcnt;
    modeBit   = 1'b0;
    pCen      = 1'b1;
    pWen      = 1'b1;
    pAddr     = '0;
    xCen      = 1'b1;
    xWen      = 1'b1;
    xAddr     = '0;
    ofRd      = 1'b0;
    l0Wr      = 1'b0;
    exec      = 1'b0;
    load      = 1'b0;

    // Results may come out of the FIFO while activations are still streaming;
    // both phases share the write counter so nothing is lost.
    drainWr = (state == XSTREAM || state == DRAIN) && ofifo_valid && (wcnt < numX);
    if (drainWr) begin
      pCen     = 1'b0;
      pWen     = 1'b0;
      pAddr    = pBase + wcnt;
      ofRd     = 1'b1;
      wcntNext = wcnt + 1'b1;
    end

    if (state != IDLE && state != DONE) modeBit = modeQ;

    case (state)
      IDLE: begin
        cntNext  = '0;
        wcntNext = '0;
        if (start) begin
          if (!mode)            stateNext = WLOAD;
          else if (num_x == '0) stateNext = DONE;
          else                  stateNext = XSTREAM;
        end
      end
      WLOAD: begin
        // l0_wr trails the read by one cycle to cover SRAM read latency
        if (cnt < LastWload) begin
          xCen  = 1'b0;
          xAddr = wBase + cnt[addr_bw-1:0];
        end
        if (cnt != '0) l0Wr = 1'b1;
        if (cnt == LastWload) begin
          cntNext   = '0;
          stateNext = WEXEC;
        end else begin
          cntNext = cnt + 1'b1;
        end
      end
      WEXEC: begin
        load = 1'b1;
        if (cnt == LastWexec) begin
          cntNext   = '0;
          stateNext = (numX == '0) ? DONE : XSTREAM;
        end else begin
          cntNext = cnt + 1'b1;
        end
      end
      XSTREAM: begin
        if (cnt < {1'b0, numX}) begin
          xCen  = 1'b0;
          xAddr = xBase + cnt[addr_bw-1:0];
        end
        if (cnt != '0) begin
          l0Wr = 1'b1;
          exec = 1'b1;
        end
        if (cnt == {1'b0, numX}) begin
          cntNext   = '0;
          stateNext = (wcntNext == numX) ? DONE : DRAIN;
        end else begin
          cntNext = cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (wcntNext == numX) stateNext = DONE;
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase

    instNext = {modeBit, 1'b0, pCen, pWen, pAddr, xCen, xWen, xAddr,
                1'b0, ofRd, 2'b00, l0Wr, exec, load};
    if (state == IDLE || state == DONE) instNext = IdleWord;
  end

  // Outputs are registered from the current state, so they trail the state by one edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      wcnt  <= '0;
      modeQ <= 1'b0;
      wBase <= '0;
      xBase <= '0;
      pBase <= '0;
      numX  <= '0;
      inst  <= IdleWord;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      wcnt  <= wcntNext;
      inst  <= instNext;
      busy  <= (state != IDLE);
      done  <= (state == DONE);
      if (state == IDLE && start) begin
        modeQ <= mode;
        wBase <= w_base;
        xBase <= x_base;
        pBase <= p_base;
        numX  <= num_x;
      end
    end
  end

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Self-checking bench for core_seq_ctrl: every pass is compared cycle by cycle against
// an expected instruction trace built from the phase lengths and address rules.
module tb_core_seq_ctrl;

  localparam int ROW = 8;
  localparam int COL = 8;
  localparam logic [34:0] IDLE_WORD = 35'h1800C0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [10:0] w_base = '0;
  logic [10:0] x_base = '0;
  logic [10:0] p_base = '0;
  logic [10:0] num_x = '0;
  logic        ofifo_valid = 1'b0;
  logic [34:0] inst;
  logic        busy;
  logic        done;

  int total = 0;
  int bad = 0;

  core_seq_ctrl #(.row(ROW), .col(COL), .addr_bw(11)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .w_base(w_base), .x_base(x_base), .p_base(p_base), .num_x(num_x),
    .ofifo_valid(ofifo_valid), .inst(inst), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Runs one pass; vKind selects the ofifo_valid pattern, ghostAt the cycle of an ignored start.
  task automatic runPass(input logic m, input logic [10:0] wb, input logic [10:0] xb,
                         input logic [10:0] pb, input logic [10:0] nx,
                         input int vKind, input int ghostAt, input string tag);
    int xs0, wr, doneAt, k;
    bit finished;
    logic v;
    logic [34:0] exp;
    logic expBusy, expDone;
    logic [10:0] a;
    xs0 = m ? 0 : 2 * ROW + COL + 1;
    wr = 0;
    doneAt = -1;
    finished = 0;
    mode = m; w_base = wb; x_base = xb; p_base = pb; num_x = nx;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    mode = ~m; w_base = 11'($urandom); x_base = 11'($urandom);
    p_base = 11'($urandom); num_x = 11'($urandom);
    total++;
    if (busy !== 1'b0 || inst !== IDLE_WORD) begin
      bad++;
      $display("[TB] FAIL %s accept-edge: busy=%b inst=%h, required busy=0 inst=%h",
               tag, busy, inst, IDLE_WORD);
    end
    for (int c = 0; c < 5000 && !finished; c++) begin
      case (vKind)
        0: v = (c >= xs0);
        1: v = (c >= xs0) && ((c - xs0) % 3 == 0);
        2: v = 1'($urandom);
        default: v = (c > xs0 + int'(nx));
      endcase
      ofifo_valid = v;
      start = (c == ghostAt);
      @(posedge clk); #1;
      start = 1'b0;

      exp = IDLE_WORD;
      expBusy = 1'b1;
      expDone = 1'b0;
      if (doneAt >= 0) begin
        expBusy = 1'b0;
        finished = 1;
      end else if ((nx == 0 && c == xs0) || (c > xs0 + int'(nx) && wr == int'(nx))) begin
        expDone = 1'b1;
        doneAt = c;
      end else begin
        exp[34] = m;
        if (!m && c <= ROW) begin
          if (c < ROW) begin
            a = wb + 11'(c);
            exp[19] = 1'b0;
            exp[17:7] = a;
          end
          if (c >= 1) exp[2] = 1'b1;
        end else if (c < xs0) begin
          exp[0] = 1'b1;
        end else begin
          k = c - xs0;
          if (k < int'(nx)) begin
            a = xb + 11'(k);
            exp[19] = 1'b0;
            exp[17:7] = a;
          end
          if (k >= 1 && k <= int'(nx)) begin
            exp[2] = 1'b1;
            exp[1] = 1'b1;
          end
          if (v && wr < int'(nx)) begin
            a = pb + 11'(wr);
            exp[32] = 1'b0;
            exp[31] = 1'b0;
            exp[30:20] = a;
            exp[5] = 1'b1;
            wr++;
          end
        end
      end

      total++;
      if (inst !== exp) begin
        bad++;
        $display("[TB] FAIL %s inst cycle %0d: got %h, required %h", tag, c, inst, exp);
      end
      total++;
      if (busy !== expBusy) begin
        bad++;
        $display("[TB] FAIL %s busy cycle %0d: got %b, required %b", tag, c, busy, expBusy);
      end
      total++;
      if (done !== expDone) begin
        bad++;
        $display("[TB] FAIL %s done cycle %0d: got %b, required %b", tag, c, done, expDone);
      end
    end
    ofifo_valid = 1'b0;
    total++;
    if (!finished) begin
      bad++;
      $display("[TB] FAIL %s timeout: pass finished=%0d, required 1", tag, finished);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      total++;
      if (inst !== IDLE_WORD || busy !== 1'b0 || done !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset idle %0d: inst=%h busy=%b done=%b, required %h 0 0",
                 i, inst, busy, done, IDLE_WORD);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ws_basic();
    runPass(1'b0, 11'd0, 11'd8, 11'd0, 11'd4, 0, -1, "ws_basic");
    runPass(1'b0, 11'd100, 11'd300, 11'd50, 11'd10, 0, -1, "ws_len10");
  endtask

  task automatic test_os();
    runPass(1'b1, 11'($urandom), 11'($urandom), 11'($urandom), 11'd3, 0, -1, "os");
  endtask

  task automatic test_backpressure();
    runPass(1'b0, 11'd16, 11'd40, 11'd200, 11'd4, 1, -1, "backpressure_ws");
    runPass(1'b1, 11'd0, 11'd7, 11'd9, 11'd4, 1, -1, "backpressure_os");
    runPass(1'b1, 11'd0, 11'd7, 11'd9, 11'd5, 3, -1, "drain_only");
  endtask

  task automatic test_boundaries();
    runPass(1'b0, 11'd5, 11'd9, 11'd3, 11'd0, 0, -1, "ws_num0");
    runPass(1'b1, 11'd5, 11'd9, 11'd3, 11'd0, 0, -1, "os_num0");
    runPass(1'b0, 11'd2044, 11'd2046, 11'd2045, 11'd4, 2, -1, "wrap");
  endtask

  task automatic test_back_to_back();
    runPass(1'b0, 11'd1, 11'd20, 11'd30, 11'd5, 2, 3, "ghost_wload");
    runPass(1'b1, 11'd1, 11'd20, 11'd30, 11'd6, 2, 2, "ghost_xstream");
  endtask

  task automatic test_midreset();
    mode = 1'b1; w_base = '0; x_base = 11'd12; p_base = '0; num_x = 11'd6;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ofifo_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    ofifo_valid = 1'b0;
    total++;
    if (inst !== IDLE_WORD || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midreset: inst=%h busy=%b done=%b, required %h 0 0",
               inst, busy, done, IDLE_WORD);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("[TB] FAIL midreset quiet %0d: done=%b busy=%b, required 0 0", i, done, busy);
      end
    end
    runPass(1'b0, 11'd3, 11'd50, 11'd60, 11'd4, 0, -1, "after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++)
      runPass(1'($urandom), 11'($urandom), 11'($urandom), 11'($urandom),
              11'($urandom_range(0, 12)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 30)), "random");
  endtask

  initial begin
    test_reset();
    test_ws_basic();
    test_os();
    test_backpressure();
    test_boundaries();
    test_back_to_back();
    test_midreset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
